// File: rtl/temp_control.sv
// Thermostat FSM: drives a heater or a cooler from an 8-bit temperature reading.
// Active modes are released through a hysteresis band. Heat and Cool are registered.
module temp_control #(
  parameter logic [7:0] LOW_THRESH  = 8'd65,
  parameter logic [7:0] HIGH_THRESH = 8'd85,
  parameter logic [7:0] HYST        = 8'd2
) (
  output logic       Heat,
  output logic       Cool,
  input  logic       CLK,
  input  logic [7:0] Temp,
  input  logic       Reset
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEATING = 2'd1;
  localparam logic [1:0] COOLING = 2'd2;

  // The release points are widened to 9 bits and then clamped to 0..255,
  // so that an extreme HYST cannot wrap around.
  localparam logic [8:0] LOW_SUM   = {1'b0, LOW_THRESH} + {1'b0, HYST};
  localparam logic [8:0] HIGH_DIFF = {1'b0, HIGH_THRESH} - {1'b0, HYST};
  localparam logic [7:0] HEAT_RELEASE = LOW_SUM[8]   ? 8'd255 : LOW_SUM[7:0];
  localparam logic [7:0] COOL_RELEASE = HIGH_DIFF[8] ? 8'd0   : HIGH_DIFF[7:0];

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       heat_reg;
  logic       heat_next;
  logic       cool_reg;
  logic       cool_next;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= IDLE;
      heat_reg  <= 1'b0;
      cool_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      heat_reg  <= heat_next;
      cool_reg  <= cool_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (^Temp === 1'bx) begin
      // An unknown reading parks the FSM in IDLE, so X does not reach the outputs.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Temp < LOW_THRESH)       state_next = HEATING;
          else if (Temp > HIGH_THRESH) state_next = COOLING;
          else                         state_next = IDLE;
        end
        HEATING: begin
          if (Temp > HIGH_THRESH)        state_next = COOLING;
          else if (Temp >= HEAT_RELEASE) state_next = IDLE;
          else                           state_next = HEATING;
        end
        COOLING: begin
          if (Temp < LOW_THRESH)         state_next = HEATING;
          else if (Temp <= COOL_RELEASE) state_next = IDLE;
          else                           state_next = COOLING;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // The outputs are decoded from the next state and registered together with it.
  // This gives a latency of one edge.
  always_comb begin
    heat_next = (state_next == HEATING);
    cool_next = (state_next == COOLING);
  end

  assign Heat = heat_reg;
  assign Cool = cool_reg;

endmodule

// File: tb/tb_temp_control.sv
// Randomized bench for temp_control. It runs three parameter sets (default, HYST=0,
// and a saturating set) against a threshold-rule model, with directed spot checks.
module tb_temp_control;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Temp = 8'd70;
  logic [2:0] heat_o;
  logic [2:0] cool_o;

  always #5 CLK = ~CLK;

  temp_control dut_def (
    .Heat(heat_o[0]), .Cool(cool_o[0]), .CLK(CLK), .Temp(Temp), .Reset(Reset));
  temp_control #(.LOW_THRESH(8'd65), .HIGH_THRESH(8'd85), .HYST(8'd0)) dut_h0 (
    .Heat(heat_o[1]), .Cool(cool_o[1]), .CLK(CLK), .Temp(Temp), .Reset(Reset));
  temp_control #(.LOW_THRESH(8'd0), .HIGH_THRESH(8'd1), .HYST(8'd5)) dut_sat (
    .Heat(heat_o[2]), .Cool(cool_o[2]), .CLK(CLK), .Temp(Temp), .Reset(Reset));

  int lo_p[3] = '{65, 65, 0};
  int hi_p[3] = '{85, 85, 1};
  int hy_p[3] = '{2, 0, 5};
  int mode[3];  // 0 idle, 1 heating, 2 cooling

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got {heat,cool}=%b expected %b (temp=%0d reset=%0b)",
               tag, got, exp, Temp, Reset);
    end else begin
      $display("ok   %s: {heat,cool}=%b temp=%0d reset=%0b", tag, got, Temp, Reset);
    end
  endtask

  function automatic int model_next(int m, int t, int lo, int hi, int hy);
    int rel_heat, rel_cool;
    rel_heat = (lo + hy > 255) ? 255 : lo + hy;
    rel_cool = (hi - hy < 0) ? 0 : hi - hy;
    if (m == 1) return (t > hi) ? 2 : (t >= rel_heat) ? 0 : 1;
    if (m == 2) return (t < lo) ? 1 : (t <= rel_cool) ? 0 : 2;
    return (t < lo) ? 1 : (t > hi) ? 2 : 0;
  endfunction

  // One clock step. A directed value in exp (with use_exp=1) is also checked on the default instance.
  task automatic step(input string tag, input int t, input bit rst,
                      input bit use_exp, input logic [1:0] exp);
    logic [1:0] want;
    Temp  = t[7:0];
    Reset = rst;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      mode[i] = rst ? 0 : model_next(mode[i], t, lo_p[i], hi_p[i], hy_p[i]);
      want = {mode[i] == 1, mode[i] == 2};
      check($sformatf("%s/inst%0d", tag, i), {heat_o[i], cool_o[i]}, want);
    end
    if (use_exp) check({tag, "/directed"}, {heat_o[0], cool_o[0]}, exp);
  endtask

  int t;
  int picks[12] = '{0, 1, 2, 6, 40, 64, 65, 66, 67, 83, 84, 85};

  initial begin
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    step("reset",     70, 1'b1, 1'b1, 2'b00);
    step("idle70",    70, 1'b0, 1'b1, 2'b00);
    step("cool93",    93, 1'b0, 1'b1, 2'b01);
    step("heat60",    60, 1'b0, 1'b1, 2'b10);
    step("hold65",    65, 1'b0, 1'b1, 2'b10);
    step("hold66",    66, 1'b0, 1'b1, 2'b10);
    step("rel67",     67, 1'b0, 1'b1, 2'b00);
    step("cool93b",   93, 1'b0, 1'b1, 2'b01);
    step("hold85",    85, 1'b0, 1'b1, 2'b01);
    step("hold84",    84, 1'b0, 1'b1, 2'b01);
    step("rel83",     83, 1'b0, 1'b1, 2'b00);
    step("idle85",    85, 1'b0, 1'b1, 2'b00);
    step("idle65",    65, 1'b0, 1'b1, 2'b00);
    step("heat40",    40, 1'b0, 1'b1, 2'b10);
    step("rst40",     40, 1'b1, 1'b1, 2'b00);
    step("resume40",  40, 1'b0, 1'b1, 2'b10);
    step("direct200", 200, 1'b0, 1'b1, 2'b01);
    step("rstcool",   200, 1'b1, 1'b1, 2'b00);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       t = $urandom_range(0, 255);
        1:       t = picks[$urandom_range(0, 11)];
        default: t = $urandom_range(60, 90);
      endcase
      step($sformatf("rnd%0d", n), t, ($urandom_range(0, 39) == 0), 1'b0, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/temp_control.md
TEMP_CONTROL -- requirements
Module: temp_control

Interface
REQ-001 Parameter LOW_THRESH, default 8'd65, temperature below which heating is requested.
REQ-002 Parameter HIGH_THRESH, default 8'd85, temperature above which cooling is requested.
REQ-003 Parameter HYST, default 8'd2, hysteresis band used when releasing an active mode.
REQ-004 Port order SHALL be positional: Heat, Cool, CLK, Temp, Reset.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Temp  input  8  unsigned current temperature, 0..255.
REQ-008 Heat  output  1  registered heater enable.
REQ-009 Cool  output  1  registered cooler enable.

Function
REQ-010 The design SHALL be a 3-state FSM: IDLE, HEATING, COOLING; Heat=1 only in HEATING, Cool=1 only in COOLING.
REQ-011 Heat and Cool SHALL never both be 1 in any cycle.
REQ-012 Outputs SHALL be registered and decoded from state: a Temp change sampled at edge N is reflected on Heat/Cool right after edge N (1-cycle latency).
REQ-013 Temp comparisons SHALL be unsigned 8-bit; threshold +/- HYST arithmetic SHALL use 9-bit intermediates and saturate at 0 and 255.
REQ-014 IDLE: Temp < LOW_THRESH -> HEATING; Temp > HIGH_THRESH -> COOLING; otherwise stay IDLE.
REQ-015 HEATING: Temp > HIGH_THRESH -> COOLING directly; else Temp >= LOW_THRESH + HYST -> IDLE; else stay.
REQ-016 COOLING: Temp < LOW_THRESH -> HEATING directly; else Temp <= HIGH_THRESH - HYST -> IDLE; else stay.
REQ-017 Boundaries: Temp == LOW_THRESH or == HIGH_THRESH SHALL not start any mode from IDLE.
REQ-018 Within the hysteresis band (LOW_THRESH <= Temp < LOW_THRESH+HYST while HEATING; HIGH_THRESH-HYST < Temp <= HIGH_THRESH while COOLING) the current mode SHALL be held.
REQ-019 HYST = 0 SHALL give plain threshold behaviour with no hold band.
REQ-020 Unreachable state encodings SHALL return to IDLE at the next edge.
REQ-021 If Temp is X/Z (simulation) the FSM SHALL be driven to IDLE rather than propagate X to outputs.

Reset
REQ-022 Reset=1 at a rising edge SHALL force state IDLE, Heat=0, Cool=0, overriding all Temp conditions.
REQ-023 Reset asserted mid-operation (HEATING or COOLING) SHALL clear outputs at that same edge; normal evaluation resumes at the first edge with Reset=0.
REQ-024 Before the first reset, output values are undefined; reset SHALL be applied before checking.

Verification
REQ-025 Reset pulse, then Temp=70, wait one edge -> Heat=0, Cool=0 (IDLE).
REQ-026 From IDLE, Temp=93, one edge -> Heat=0, Cool=1.
REQ-027 From COOLING, Temp=60, one edge -> Heat=1, Cool=0 (direct transition).
REQ-028 HEATING, Temp=65 -> Heat stays 1; Temp=67 -> next edge Heat=0, Cool=0.
REQ-029 COOLING, Temp=84 -> Cool stays 1; Temp=83 -> next edge Cool=0; Temp=85 from IDLE -> stays IDLE.
REQ-030 In HEATING, assert Reset with Temp=40 -> Heat=0, Cool=0 at that edge; deassert -> Heat=1 one edge later.
